// File: rtl/hsv2rgb.sv
// hsv2rgb: pipelined HSV-to-RGB converter for the HDMI video path.
//
// Parameters:
//   SECTOR    - hue codes per 60-degree sector (6 sectors span H = 0..255).
//   EXTRA_REG - 0 or 1; adds one output register stage. Latency = 4 + EXTRA_REG.
//
// Ports:
//   clk        pixel clock, all logic rising-edge
//   rst        synchronous active-high reset, clears every pipeline register
//   ce         clock enable; the pixel pipeline and the sync delay line hold when 0
//   de_in      data enable, aligned with H/S/V
//   hsync_in   horizontal sync
//   vsync_in   vertical sync
//   H, S, V    8-bit hue / saturation / value
//   red, green, blue             8-bit converted pixel
//   de_out, hsync_out, vsync_out syncs delayed by the pipeline latency
//
// Optional macro HSV2RGB_BLANK_EN: when defined, RGB is forced to 0 at the
// final stage whenever the delayed de is 0. Latency is unchanged.
module hsv2rgb #(
  parameter int unsigned SECTOR    = 43,
  parameter int unsigned EXTRA_REG = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] H,
  input  logic [7:0] S,
  input  logic [7:0] V,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam int unsigned LAT = 4 + EXTRA_REG;

  // Stage 1 combinational: sector by comparator chain, fractional hue.
  logic [2:0] w_region;
  logic [7:0] w_base;
  logic [7:0] w_diff;
  logic [7:0] w_f;

  // Highest threshold passed wins; stopping at k=5 clamps the region.
  always_comb begin
    w_region = '0;
    for (int unsigned k = 1; k <= 5; k++) begin
      if (32'(H) >= SECTOR * k) w_region = 3'(k);
    end
  end

  assign w_base = 8'(SECTOR * 32'(w_region));
  assign w_diff = H - w_base;
  assign w_f    = 8'(w_diff * 8'd6);

  logic [7:0] r1_s, r1_v, r1_f;
  logic [2:0] r1_reg;
  logic       r1_sz;

  logic [7:0] r2_a, r2_b, r2_c, r2_v;
  logic [2:0] r2_reg;
  logic       r2_sz;

  logic [7:0] r3_p, r3_q, r3_t, r3_v;
  logic [2:0] r3_reg;
  logic       r3_sz;

  logic [7:0] r4_r, r4_g, r4_b;

  // Sync delay line, one entry per pipeline stage: {de, hsync, vsync}.
  logic [LAT-1:0][2:0] r_sd;

  logic [7:0] w_r, w_g, w_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_s <= '0; r1_v <= '0; r1_f <= '0; r1_reg <= '0; r1_sz <= 1'b0;
      r2_a <= '0; r2_b <= '0; r2_c <= '0; r2_v <= '0; r2_reg <= '0; r2_sz <= 1'b0;
      r3_p <= '0; r3_q <= '0; r3_t <= '0; r3_v <= '0; r3_reg <= '0; r3_sz <= 1'b0;
      r4_r <= '0; r4_g <= '0; r4_b <= '0;
      r_sd <= '0;
    end else if (ce) begin
      // S1
      r1_s   <= S;
      r1_v   <= V;
      r1_f   <= w_f;
      r1_reg <= w_region;
      r1_sz  <= (S == 8'd0);
      // S2
      r2_a   <= 8'(({8'd0, r1_s} * {8'd0, r1_f}) >> 8);
      r2_b   <= 8'(({8'd0, r1_s} * {8'd0, 8'd255 - r1_f}) >> 8);
      r2_c   <= 8'd255 - r1_s;
      r2_v   <= r1_v;
      r2_reg <= r1_reg;
      r2_sz  <= r1_sz;
      // S3
      r3_p   <= 8'(({8'd0, r2_v} * {8'd0, r2_c}) >> 8);
      r3_q   <= 8'(({8'd0, r2_v} * {8'd0, 8'd255 - r2_a}) >> 8);
      r3_t   <= 8'(({8'd0, r2_v} * {8'd0, 8'd255 - r2_b}) >> 8);
      r3_v   <= r2_v;
      r3_reg <= r2_reg;
      r3_sz  <= r2_sz;
      // S4
      r4_r   <= w_r;
      r4_g   <= w_g;
      r4_b   <= w_b;
      // Syncs
      r_sd[0] <= {de_in, hsync_in, vsync_in};
      for (int unsigned i = 1; i < LAT; i++) r_sd[i] <= r_sd[i-1];
    end
  end

  // S4 output mux; r_sd[2] is the sync entry moving into the S4-aligned slot.
  always_comb begin
    w_r = r3_v;
    w_g = r3_t;
    w_b = r3_p;
    case (r3_reg)
      3'd0: begin w_r = r3_v; w_g = r3_t; w_b = r3_p; end
      3'd1: begin w_r = r3_q; w_g = r3_v; w_b = r3_p; end
      3'd2: begin w_r = r3_p; w_g = r3_v; w_b = r3_t; end
      3'd3: begin w_r = r3_p; w_g = r3_q; w_b = r3_v; end
      3'd4: begin w_r = r3_t; w_g = r3_p; w_b = r3_v; end
      default: begin w_r = r3_v; w_g = r3_p; w_b = r3_q; end
    endcase
    if (r3_sz) begin
      w_r = r3_v;
      w_g = r3_v;
      w_b = r3_v;
    end
`ifdef HSV2RGB_BLANK_EN
    if (!r_sd[2][2]) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end
`endif
  end

  generate
    if (EXTRA_REG != 0) begin : g_extra
      logic [7:0] r5_r, r5_g, r5_b;
      always_ff @(posedge clk) begin
        if (rst) begin
          r5_r <= '0; r5_g <= '0; r5_b <= '0;
        end else if (ce) begin
          r5_r <= r4_r; r5_g <= r4_g; r5_b <= r4_b;
        end
      end
      assign red   = r5_r;
      assign green = r5_g;
      assign blue  = r5_b;
    end else begin : g_noextra
      assign red   = r4_r;
      assign green = r4_g;
      assign blue  = r4_b;
    end
  endgenerate

  assign de_out    = r_sd[LAT-1][2];
  assign hsync_out = r_sd[LAT-1][1];
  assign vsync_out = r_sd[LAT-1][0];

endmodule

// File: doc/hsv2rgb.md
Name: hsv2rgb

Overview:
- Pipelined HSV-to-RGB converter; the inverse of the team's rgb2hsv block in the neuro_skin HDMI video path.
- Converts 8-bit H/S/V pixels, for example after skin-mask recolouring, back to 8-bit RGB for the HDMI encoder.
- de/hsync/vsync are delayed to stay cycle-aligned with the pixel data.

Parameters:
- SECTOR, 43, hue codes per 60-degree sector (H full scale 0..255 = 6 sectors).
- EXTRA_REG, 0, 0 or 1; adds one output register stage. Latency = 4 + EXTRA_REG.

Ports:
- clk  in  1  pixel clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when 0 the whole pipeline, including the sync delay line, holds.
- de_in  in  1  data enable, aligned with H/S/V.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- H  in  8  hue (sector = H/SECTOR).
- S  in  8  saturation, 0..255.
- V  in  8  value, 0..255.
- red  out  8  red result.
- green  out  8  green result.
- blue  out  8  blue result.
- de_out  out  1  de_in delayed by latency.
- hsync_out  out  1  hsync_in delayed by latency.
- vsync_out  out  1  vsync_in delayed by latency.

Behaviour:
- Reset: when rst=1 at a clk edge, all pipeline registers clear regardless of ce. red/green/blue/de_out/hsync_out/vsync_out = 0 from the next cycle. Reset applied mid-stream discards all in-flight pixels; no partial outputs emerge afterwards.
- Pipeline (advances only when ce=1):
  - S1: register H,S,V,syncs. region = H/SECTOR, computed by comparator chain (no divider), clamped to 5. f = (H - SECTOR*region)*6, 8 bits. H=255 gives region 5, f=240.
  - S2: a = (S*f)>>8; b = (S*(255-f))>>8; c = 255-S. All 8-bit, truncating.
  - S3: p = (V*c)>>8; q = (V*(255-a))>>8; t = (V*(255-b))>>8. 16-bit products, keep bits [15:8], truncate (no rounding).
  - S4: mux to RGB by region:
    - 0: (V,t,p)
    - 1: (q,V,p)
    - 2: (p,V,t)
    - 3: (p,q,V)
    - 4: (t,p,V)
    - 5: (V,p,q)
  - Optional EXTRA_REG stage follows S4.
- S=0 special case: output (V,V,V) exactly, decided at S4 from a registered S==0 flag. This bypasses truncation error.
- Syncs: de/hsync/vsync pass through a shift register of the same depth, gated by the same ce. Sync and pixel stay aligned under any ce pattern.
- Throughput: one pixel per ce-cycle. No backpressure; no handshake beyond ce.
- ce=0 for N cycles: outputs frozen at last values; resume with no loss or duplication.
- Arithmetic never overflows 8 bits at outputs. All intermediates are unsigned.
- Pixel data is computed regardless of de_in (unless the optional feature is enabled).

Optional Feature:
- Macro HSV2RGB_BLANK_EN.
- Defined: at the final stage, red/green/blue are forced to 0 whenever the delayed de is 0. This gives clean blanking for the HDMI encoder.
- Undefined: RGB outputs carry converted data regardless of de. Latency is unchanged either way.

Test Plan:
- Reset: rst=1 for 3 cycles with random inputs -> all outputs 0; after release with ce=1 and input (H,S,V)=(0,0,0), de_in=1 -> outputs (0,0,0) and de_out=1 exactly 4 cycles after the input cycle.
- Known pixel: H=159,S=203,V=249, de/hs/vs=1 for one cycle -> 4 cycles later red=50, green=109, blue=249 and de_out=hsync_out=vsync_out=1 for exactly one cycle. Round-trip check against the rgb2hsv pixel (50,100,250).
- Primaries: (0,255,255) -> (255,0,0); (43,255,255) -> (254,255,0); (255,255,255) -> region 5, f=240 -> (255,0,15).
- Gray bypass: S=0, V=128, any H (0, 100, 255) -> (128,128,128) each.
- ce stall: stream 8 distinct pixels with ce toggled 1,0,0,1,... -> output sequence identical to the ce=1 run, sync bits aligned, no repeats.
- Blanking (with HSV2RGB_BLANK_EN): pixel (0,255,255) with de_in=0 -> RGB=(0,0,0), de_out=0. Without the macro, the same stimulus gives (255,0,0).
